// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Two-stage pipeline: issue register drives the ALU, response register captures its output.
module alu_arbiter #(
  parameter int unsigned WORD_BITWIDTH = 32,
  parameter int unsigned OP_BITWIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OP_BITWIDTH-1:0]   req0_operation,
  input  logic [WORD_BITWIDTH-1:0] req0_addend1,
  input  logic [WORD_BITWIDTH-1:0] req0_addend2,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OP_BITWIDTH-1:0]   req1_operation,
  input  logic [WORD_BITWIDTH-1:0] req1_addend1,
  input  logic [WORD_BITWIDTH-1:0] req1_addend2,

  output logic [OP_BITWIDTH-1:0]   alu_operation,
  output logic [WORD_BITWIDTH-1:0] alu_addend1,
  output logic [WORD_BITWIDTH-1:0] alu_addend2,
  input  logic [WORD_BITWIDTH-1:0] alu_result,
  input  logic                     alu_zero,

  output logic                     resp0_valid,
  output logic                     resp1_valid,
  output logic [WORD_BITWIDTH-1:0] resp_result,
  output logic                     resp_zero
);

  logic                     issue_valid_q, issue_valid_d;
  logic                     issue_owner_q, issue_owner_d;
  logic [OP_BITWIDTH-1:0]   issue_op_q, issue_op_d;
  logic [WORD_BITWIDTH-1:0] issue_a_q, issue_a_d;
  logic [WORD_BITWIDTH-1:0] issue_b_q, issue_b_d;
  // 1 means requester 1 was granted last, so requester 0 wins the next contention.
  logic                     last_grant_q, last_grant_d;
  logic                     resp0_valid_q, resp0_valid_d;
  logic                     resp1_valid_q, resp1_valid_d;
  logic [WORD_BITWIDTH-1:0] resp_result_q, resp_result_d;
  logic                     resp_zero_q, resp_zero_d;

  logic grant0, grant1;
  logic accept0, accept1;

  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_grant_q);
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = grant0 & ~flush & rst_n;
    req1_ready = grant1 & ~flush & rst_n;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
  end

  always_comb begin
    issue_valid_d = accept0 | accept1;
    issue_owner_d = issue_owner_q;
    issue_op_d    = issue_op_q;
    issue_a_d     = issue_a_q;
    issue_b_d     = issue_b_q;
    last_grant_d  = last_grant_q;
    if (accept0) begin
      issue_owner_d = 1'b0;
      issue_op_d    = req0_operation;
      issue_a_d     = req0_addend1;
      issue_b_d     = req0_addend2;
      last_grant_d  = 1'b0;
    end else if (accept1) begin
      issue_owner_d = 1'b1;
      issue_op_d    = req1_operation;
      issue_a_d     = req1_addend1;
      issue_b_d     = req1_addend2;
      last_grant_d  = 1'b1;
    end
  end

  always_comb begin
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    if (!flush && issue_valid_q) begin
      resp0_valid_d = ~issue_owner_q;
      resp1_valid_d = issue_owner_q;
      resp_result_d = alu_result;
      resp_zero_d   = alu_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_owner_q <= 1'b0;
      issue_op_q    <= '0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      last_grant_q  <= 1'b1;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_owner_q <= issue_owner_d;
      issue_op_q    <= issue_op_d;
      issue_a_q     <= issue_a_d;
      issue_b_q     <= issue_b_d;
      last_grant_q  <= last_grant_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  assign alu_operation = issue_op_q;
  assign alu_addend1   = issue_a_q;
  assign alu_addend2   = issue_b_q;
  assign resp0_valid   = resp0_valid_q;
  assign resp1_valid   = resp1_valid_q;
  assign resp_result   = resp_result_q;
  assign resp_zero     = resp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; includes a behavioural ALU on the shared-ALU ports.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_operation, req1_operation, alu_operation;
  logic [31:0] req0_addend1, req0_addend2, req1_addend1, req1_addend2;
  logic [31:0] alu_addend1, alu_addend2, alu_result, resp_result;
  logic        alu_zero, resp0_valid, resp1_valid, resp_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WORD_BITWIDTH(32), .OP_BITWIDTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_operation (req0_operation),
    .req0_addend1   (req0_addend1),
    .req0_addend2   (req0_addend2),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_operation (req1_operation),
    .req1_addend1   (req1_addend1),
    .req1_addend2   (req1_addend2),
    .alu_operation  (alu_operation),
    .alu_addend1    (alu_addend1),
    .alu_addend2    (alu_addend2),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .resp0_valid    (resp0_valid),
    .resp1_valid    (resp1_valid),
    .resp_result    (resp_result),
    .resp_zero      (resp_zero)
  );

  always_comb begin
    alu_result = 32'h0;
    case (alu_operation)
      4'd0: alu_result = alu_addend1 & alu_addend2;
      4'd1: alu_result = alu_addend1 | alu_addend2;
      4'd2: alu_result = alu_addend1 + alu_addend2;
      4'd3: alu_result = alu_addend1 ^ alu_addend2;
      4'd4: alu_result = alu_addend1 << alu_addend2[4:0];
      4'd5: alu_result = alu_addend1 >> alu_addend2[4:0];
      4'd6: alu_result = alu_addend1 - alu_addend2;
      4'd7: alu_result = {31'h0, $signed(alu_addend1) < $signed(alu_addend2)};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    req0_valid = 1'b0; req0_operation = 4'd0; req0_addend1 = 32'd0; req0_addend2 = 32'd0;
    req1_valid = 1'b0; req1_operation = 4'd0; req1_addend1 = 32'd0; req1_addend2 = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    tick();
    tick();
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    total++;
    if ({alu_operation, alu_addend1, alu_addend2} !== 68'h0) begin
      bad++;
      $display("FAIL reset_issue: got %h/%h/%h expected 0/0/0",
               alu_operation, alu_addend1, alu_addend2);
    end
    total++;
    if ({resp0_valid, resp1_valid, resp_zero, resp_result} !== 35'h0) begin
      bad++;
      $display("FAIL reset_resp: got v0=%b v1=%b z=%b r=%h expected all 0",
               resp0_valid, resp1_valid, resp_zero, resp_result);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_req0();
    do_reset();
    req0_valid = 1'b1; req0_operation = 4'd2; req0_addend1 = 32'd5; req0_addend2 = 32'd7;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    #1;
    total++;
    if (alu_operation !== 4'd2 || alu_addend1 !== 32'd5 || alu_addend2 !== 32'd7) begin
      bad++;
      $display("FAIL single_issue: got %h/%0d/%0d expected 2/5/7",
               alu_operation, alu_addend1, alu_addend2);
    end
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b00) begin
      bad++;
      $display("FAIL single_early_resp: got %b expected 00", {resp0_valid, resp1_valid});
    end
    tick();
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b10 || resp_result !== 32'd12 || resp_zero !== 1'b0) begin
      bad++;
      $display("FAIL single_resp: got v=%b r=%0d z=%b expected v=10 r=12 z=0",
               {resp0_valid, resp1_valid}, resp_result, resp_zero);
    end
    tick();
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b00 || resp_result !== 32'd12) begin
      bad++;
      $display("FAIL single_pulse: got v=%b r=%0d expected v=00 r=12 (held)",
               {resp0_valid, resp1_valid}, resp_result);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_operation = 4'd6; req0_addend1 = 32'd9;    req0_addend2 = 32'd9;
    req1_valid = 1'b1; req1_operation = 4'd1; req1_addend1 = 32'hF0;   req1_addend2 = 32'h0F;
    for (int k = 0; k < 6; k++) begin
      #1;
      total++;
      if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL contention_grant[%0d]: got %b expected %b", k,
                 {req0_ready, req1_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (k >= 2) begin
        total++;
        if ((k % 2 == 0) ?
            ({resp0_valid, resp1_valid} !== 2'b10 || resp_result !== 32'h0 || resp_zero !== 1'b1) :
            ({resp0_valid, resp1_valid} !== 2'b01 || resp_result !== 32'hFF || resp_zero !== 1'b0))
        begin
          bad++;
          $display("FAIL contention_resp[%0d]: got v=%b r=%h z=%b expected %s", k,
                   {resp0_valid, resp1_valid}, resp_result, resp_zero,
                   (k % 2 == 0) ? "v=10 r=0 z=1" : "v=01 r=ff z=0");
        end
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_req1_then_both();
    do_reset();
    req1_valid = 1'b1; req1_operation = 4'd2; req1_addend1 = 32'd1; req1_addend2 = 32'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        bad++;
        $display("FAIL req1_alone[%0d]: got %b expected 01", k, {req0_ready, req1_ready});
      end
      tick();
    end
    req0_valid = 1'b1; req0_operation = 4'd2; req0_addend1 = 32'd2; req0_addend2 = 32'd2;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL both_first: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++;
      $display("FAIL both_second: got %b expected 01", {req0_ready, req1_ready});
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    req0_valid = 1'b1; req0_operation = 4'd3; req0_addend1 = 32'hA; req0_addend2 = 32'h3;
    tick();
    req0_valid = 1'b0;
    flush = 1'b1;
    req1_valid = 1'b1; req1_operation = 4'd2; req1_addend1 = 32'd1; req1_addend2 = 32'd2;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL flush_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    tick();
    flush = 1'b0;
    #1;
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b00) begin
      bad++;
      $display("FAIL flush_discard: got %b expected 00", {resp0_valid, resp1_valid});
    end
    total++;
    if (alu_operation !== 4'd3 || alu_addend1 !== 32'hA) begin
      bad++;
      $display("FAIL flush_hold: got %h/%h expected 3/a", alu_operation, alu_addend1);
    end
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++;
      $display("FAIL flush_after_ready: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    #1;
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b00) begin
      bad++;
      $display("FAIL flush_gap: got %b expected 00", {resp0_valid, resp1_valid});
    end
    tick();
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b01 || resp_result !== 32'd3) begin
      bad++;
      $display("FAIL flush_req1_resp: got v=%b r=%0d expected v=01 r=3",
               {resp0_valid, resp1_valid}, resp_result);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_valid = 1'b1; req0_operation = 4'd2; req0_addend1 = 32'd5; req0_addend2 = 32'd7;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_operation = 4'd1; req1_addend1 = 32'hF0; req1_addend2 = 32'h0F;
    tick();
    req1_valid = 1'b0;
    total++;
    if (resp0_valid !== 1'b1 || resp_result !== 32'd12 || alu_operation !== 4'd1) begin
      bad++;
      $display("FAIL midreset_pre: got v0=%b r=%0d op=%h expected v0=1 r=12 op=1",
               resp0_valid, resp_result, alu_operation);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b00 || resp_result !== 32'h0 || resp_zero !== 1'b0) begin
      bad++;
      $display("FAIL midreset_resp: got v=%b r=%h z=%b expected v=00 r=0 z=0",
               {resp0_valid, resp1_valid}, resp_result, resp_zero);
    end
    total++;
    if ({alu_operation, alu_addend1, alu_addend2} !== 68'h0) begin
      bad++;
      $display("FAIL midreset_alu: got %h/%h/%h expected 0/0/0",
               alu_operation, alu_addend1, alu_addend2);
    end
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL midreset_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_payload_change();
    do_reset();
    req0_valid = 1'b1; req0_operation = 4'd3; req0_addend1 = 32'h55; req0_addend2 = 32'h66;
    req1_valid = 1'b1; req1_operation = 4'd0; req1_addend1 = 32'h11; req1_addend2 = 32'h22;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL payload_first: got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req1_operation = 4'd2; req1_addend1 = 32'h33; req1_addend2 = 32'h44;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01 || alu_addend1 !== 32'h55) begin
      bad++;
      $display("FAIL payload_wait: got rdy=%b a=%h expected rdy=01 a=55",
               {req0_ready, req1_ready}, alu_addend1);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (alu_operation !== 4'd2 || alu_addend1 !== 32'h33 || alu_addend2 !== 32'h44) begin
      bad++;
      $display("FAIL payload_issue: got %h/%h/%h expected 2/33/44",
               alu_operation, alu_addend1, alu_addend2);
    end
    tick();
    total++;
    if ({resp0_valid, resp1_valid} !== 2'b01 || resp_result !== 32'h77) begin
      bad++;
      $display("FAIL payload_resp: got v=%b r=%h expected v=01 r=77",
               {resp0_valid, resp1_valid}, resp_result);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_req0();
    test_contention();
    test_req1_then_both();
    test_flush();
    test_reset_mid();
    test_payload_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters (req0 = integer execute path, req1 = address/auxiliary path) under round-robin arbitration.
- Registers the granted request into an issue stage and drives the shared ALU from that stage.
- Captures the ALU output into a per-requester response register.
- Fully pipelined: one accepted operation per cycle, fixed 2-cycle latency, no response back-pressure.

Parameters:
WORD_BITWIDTH, 32, operand/result width
OP_BITWIDTH, 4, ALU operation code width (AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUBTRACT=0110, LESS_THAN=0111)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous discard of all in-flight operations
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 granted this cycle
req0_operation  in  OP_BITWIDTH  requester 0 ALU opcode
req0_addend1  in  WORD_BITWIDTH  requester 0 operand A
req0_addend2  in  WORD_BITWIDTH  requester 0 operand B
req1_valid, req1_ready, req1_operation, req1_addend1, req1_addend2  same as req0, for requester 1
alu_operation  out  OP_BITWIDTH  to shared ALU, from issue register
alu_addend1  out  WORD_BITWIDTH  to shared ALU
alu_addend2  out  WORD_BITWIDTH  to shared ALU
alu_result  in  WORD_BITWIDTH  from shared ALU (combinational)
alu_zero  in  1  from shared ALU
resp0_valid  out  1  one-cycle pulse, result for requester 0
resp1_valid  out  1  one-cycle pulse, result for requester 1
resp_result  out  WORD_BITWIDTH  captured ALU result
resp_zero  out  1  captured ALU zero flag

Behaviour:
- Reset (rst_n=0 at an edge):
  - Issue register cleared: issue_valid=0, issue_owner=0, alu_operation=4'b0000, alu_addend1=0, alu_addend2=0.
  - resp0_valid=0, resp1_valid=0, resp_result=0, resp_zero=0.
  - last_grant=1, so req0 wins the first contention.
  - Reset overrides flush and any request, and takes effect mid-operation with no partial results emitted.
- Arbitration (combinational):
  - grant0 = req0_valid & (~req1_valid | last_grant==1).
  - grant1 = req1_valid & (~req0_valid | last_grant==0).
  - reqX_ready = grantX & ~flush & rst_n.
  - At most one ready is high per cycle.
  - ready does not depend on the response path.
- Accept edge E0 (reqX_valid & reqX_ready):
  - Issue register loads operation/addend1/addend2 of requester X.
  - issue_owner=X, issue_valid=1, last_grant=X.
  - If no accept: issue_valid=0 and issue payload holds its previous value.
  - last_grant changes only on an accept.
- Cycle after E0: alu_* outputs reflect the issued payload; the ALU computes combinationally.
- Edge E1:
  - If issue_valid: resp_result/resp_zero capture alu_result/alu_zero, and resp{issue_owner}_valid=1.
  - Otherwise both resp valids are 0 and resp_result/resp_zero hold.
- Latency: accepted at edge E0 → respX_valid high during the cycle following E1 (2 cycles).
- Throughput: back-to-back accepts every cycle; alternating owners under continuous contention.
- No response back-pressure; a response not consumed in its valid cycle is lost.
- Flush (flush=1 at an edge, rst_n=1):
  - No accept.
  - issue_valid←0.
  - resp0_valid, resp1_valid←0 at that edge; the issue stage's result is discarded.
  - last_grant unchanged; payload registers hold.
  - Request arriving in the cycle after flush deasserts is accepted normally.
- Single requester valid: granted every cycle regardless of last_grant.
- Requester changing payload while not ready: allowed; only the payload at the accept edge is used.
- Opcode is forwarded unchanged; undefined opcodes are the ALU's concern.

Test Plan:
- Reset then req0 only (op ADD, 5, 7) at cycle 1: req0_ready=1 in cycle 1; alu_operation=0010, addends 5/7 in cycle 2; resp0_valid=1, resp_result=12, resp_zero=0 in cycle 3; resp1_valid=0 throughout.
- Both valid continuously from reset (req0 SUBTRACT 9,9; req1 OR 0xF0,0x0F): grants alternate 0,1,0,1. Responses alternate resp0 (result 0, zero=1) and resp1 (result 0xFF, zero=0), one per cycle, starting 2 cycles after the first grant.
- req1 alone for 3 cycles, then both valid: req0 granted first (last_grant=1). Then req1 is granted next.
- Accept req0 (XOR 0xA,0x3), then flush=1 the next cycle with req1 valid: req1_ready=0 during flush. The req0 response is discarded (resp0_valid stays 0). req1 is accepted the cycle after flush drops, with resp1_valid 2 cycles later.
- Assert rst_n=0 with an operation in the issue stage and one in the response register: the next cycle all resp valids=0, alu_* outputs=0, resp_result=0. The first post-reset contention is granted to req0.
- Payload changes while req1 waits behind req0 (last_grant=0, both valid): only the req1 payload present at its accept edge appears on alu_addend1/alu_addend2.
